// File: rtl/alu_ctrl_unit.sv
// ALU control stage: DP/MUL decode, ARM condition evaluation, CPSR flag ownership.
// Define ALU_FLAG_FWD_EN to forward same-cycle committed flags into condition evaluation.
module alu_ctrl_unit #(
    parameter int unsigned ALU_OP_W = 4,
    parameter int unsigned MUL_LAT  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [3:0]          i_OpCode,
    input  logic [3:0]          i_Cond,
    input  logic                i_IfDP,
    input  logic                i_IfMul,
    input  logic                i_Set_Condition,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [ALU_OP_W-1:0] o_ALU_OpCode,
    output logic                o_CondPass,
    output logic                o_WriteBack,
    input  logic [3:0]          i_ALU_Flags,
    output logic [3:0]          o_CPSR,
    output logic                o_Busy
);

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluAnd   = 4'd2;
    localparam logic [3:0] AluOrr   = 4'd3;
    localparam logic [3:0] AluEor   = 4'd4;
    localparam logic [3:0] AluNot   = 4'd5;
    localparam logic [3:0] AluPassB = 4'd7;
    localparam logic [3:0] AluRsb   = 4'd8;
    localparam logic [3:0] AluAdc   = 4'd9;
    localparam logic [3:0] AluSbc   = 4'd10;
    localparam logic [3:0] AluBic   = 4'd11;
    localparam logic [3:0] AluMul   = 4'd12;

    localparam bit          MulMultiCycle = (MUL_LAT > 1);
    localparam int unsigned CNT_W         = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam int unsigned CNT_INIT      = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;

    typedef enum logic [1:0] {StIdle, StMulW, StHold} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ALU_OP_W-1:0] opcode_q;
    logic                pass_q;
    logic                wb_q;
    logic                flag_wr_q;
    logic [3:0]          cpsr_q;

    logic [3:0] alu_code;
    logic       is_cmp;
    logic       cond_pass;
    logic [3:0] cond_flags;
    logic       commit;
    logic       accept;
    logic       mul_wait;

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        unique case (cond)
            4'b0000: cond_holds = z;
            4'b0001: cond_holds = !z;
            4'b0010: cond_holds = c;
            4'b0011: cond_holds = !c;
            4'b0100: cond_holds = n;
            4'b0101: cond_holds = !n;
            4'b0110: cond_holds = v;
            4'b0111: cond_holds = !v;
            4'b1000: cond_holds = c & !z;
            4'b1001: cond_holds = !c | z;
            4'b1010: cond_holds = (n == v);
            4'b1011: cond_holds = (n != v);
            4'b1100: cond_holds = !z & (n == v);
            4'b1101: cond_holds = z | (n != v);
            default: cond_holds = 1'b1;
        endcase
    endfunction

    always_comb begin
        alu_code = AluAdd;
        is_cmp   = 1'b0;
        if (i_IfMul) begin
            alu_code = AluMul;
        end else if (i_IfDP) begin
            is_cmp = (i_OpCode[3:2] == 2'b10);
            unique case (i_OpCode)
                4'b0000: alu_code = AluAnd;
                4'b0001: alu_code = AluEor;
                4'b0010: alu_code = AluSub;
                4'b0011: alu_code = AluRsb;
                4'b0100: alu_code = AluAdd;
                4'b0101: alu_code = AluAdc;
                4'b0110: alu_code = AluSbc;
                4'b0111: alu_code = AluRsb;
                4'b1000: alu_code = AluAnd;
                4'b1001: alu_code = AluEor;
                4'b1010: alu_code = AluSub;
                4'b1011: alu_code = AluAdd;
                4'b1100: alu_code = AluOrr;
                4'b1101: alu_code = AluPassB;
                4'b1110: alu_code = AluBic;
                default: alu_code = AluNot;
            endcase
        end
    end

    assign commit = (state_q == StHold) & i_ready & flag_wr_q;

`ifdef ALU_FLAG_FWD_EN
    assign cond_flags = commit ? i_ALU_Flags : cpsr_q;
    assign o_ready    = (state_q == StIdle) | ((state_q == StHold) & i_ready);
`else
    // Without forwarding, hold off the next op until the flag setter has committed.
    assign cond_flags = cpsr_q;
    assign o_ready    = (state_q == StIdle) | ((state_q == StHold) & i_ready & !flag_wr_q);
`endif

    assign cond_pass = cond_holds(i_Cond, cond_flags);
    assign accept    = i_valid & o_ready;
    assign mul_wait  = MulMultiCycle & i_IfMul & cond_pass;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = mul_wait ? StMulW : StHold;
                    cnt_d   = CNT_W'(CNT_INIT);
                end
            end
            StMulW: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StHold: begin
                if (i_ready) begin
                    if (accept) begin
                        state_d = mul_wait ? StMulW : StHold;
                        cnt_d   = CNT_W'(CNT_INIT);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            opcode_q  <= '0;
            pass_q    <= 1'b0;
            wb_q      <= 1'b0;
            flag_wr_q <= 1'b0;
            cpsr_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                opcode_q  <= ALU_OP_W'(alu_code);
                pass_q    <= cond_pass;
                wb_q      <= cond_pass & !is_cmp;
                flag_wr_q <= cond_pass & (i_Set_Condition | is_cmp);
            end
            if (commit) begin
                cpsr_q <= i_ALU_Flags;
            end
        end
    end

    assign o_valid      = (state_q == StHold);
    assign o_Busy       = (state_q == StMulW);
    assign o_ALU_OpCode = opcode_q;
    assign o_CondPass   = pass_q;
    assign o_WriteBack  = wb_q;
    assign o_CPSR       = cpsr_q;

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Self-checking bench for alu_ctrl_unit: directed table, corner sequences, random vs model.
module tb_alu_ctrl_unit;

    localparam int MUL_LAT = 3;
`ifdef ALU_FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ALU code for each DP opcode, indexed by opcode value.
    localparam logic [3:0] DP_MAP [16] = '{4'd2, 4'd4, 4'd1, 4'd8, 4'd0, 4'd9, 4'd10, 4'd8,
                                           4'd2, 4'd4, 4'd1, 4'd0, 4'd3, 4'd7, 4'd11, 4'd5};

    logic       clk;
    logic       reset;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_OpCode;
    logic [3:0] i_Cond;
    logic       i_IfDP;
    logic       i_IfMul;
    logic       i_Set_Condition;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_ALU_OpCode;
    logic       o_CondPass;
    logic       o_WriteBack;
    logic [3:0] i_ALU_Flags;
    logic [3:0] o_CPSR;
    logic       o_Busy;

    alu_ctrl_unit #(
        .ALU_OP_W(4),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_OpCode       (i_OpCode),
        .i_Cond         (i_Cond),
        .i_IfDP         (i_IfDP),
        .i_IfMul        (i_IfMul),
        .i_Set_Condition(i_Set_Condition),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_ALU_OpCode   (o_ALU_OpCode),
        .o_CondPass     (o_CondPass),
        .o_WriteBack    (o_WriteBack),
        .i_ALU_Flags    (i_ALU_Flags),
        .o_CPSR         (o_CPSR),
        .o_Busy         (o_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] code;
        logic       pass;
        logic       wb;
        logic       fw;
        int         lat;
    } exp_t;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [3:0] cond, input logic dp,
                                   input logic mul, input logic s, input logic [3:0] flags);
        exp_t e;
        logic cmp;
        cmp    = dp && !mul && (op[3:2] == 2'b10);
        e.code = mul ? 4'd12 : (dp ? DP_MAP[op] : 4'd0);
        e.pass = cond_ok(cond, flags);
        e.wb   = e.pass && !cmp;
        e.fw   = e.pass && (s || cmp);
        e.lat  = (mul && e.pass) ? MUL_LAT : 1;
        return e;
    endfunction

    typedef struct {
        logic [3:0] op;
        logic [3:0] cond;
        logic       dp;
        logic       mul;
        logic       s;
        logic [3:0] flags;
        logic [3:0] code;
        logic       pass;
        logic       wb;
        logic [3:0] cpsr_after;
        int         lat;
    } vec_t;

    vec_t vecs[21];

    task automatic drive_op(input logic [3:0] op, input logic [3:0] cond, input logic dp,
                            input logic mul, input logic s, input logic [3:0] flags);
        i_valid         = 1'b1;
        i_OpCode        = op;
        i_Cond          = cond;
        i_IfDP          = dp;
        i_IfMul         = mul;
        i_Set_Condition = s;
        i_ALU_Flags     = flags;
    endtask

    exp_t       m_op;
    logic       have_op;
    int         due;
    logic [3:0] cpsr_m;

    initial begin
        int lat;
        int bubbles;
        int busy;
        logic exp_valid, exp_busy, exp_ready, commit, acc;
        logic [3:0] cflags;

        vecs[0]  = '{4'b0100, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b0110, 4'd0,  1'b1, 1'b1, 4'b0110, 1};
        vecs[1]  = '{4'b1010, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0100, 4'd1,  1'b1, 1'b0, 4'b0100, 1};
        vecs[2]  = '{4'b1101, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1111, 4'd7,  1'b1, 1'b1, 4'b0100, 1};
        vecs[3]  = '{4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b1111, 4'd2,  1'b0, 1'b0, 4'b0100, 1};
        vecs[4]  = '{4'b1001, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b1000, 4'd4,  1'b1, 1'b0, 4'b1000, 1};
        vecs[5]  = '{4'b1100, 4'b1100, 1'b1, 1'b0, 1'b1, 4'b0000, 4'd3,  1'b0, 1'b0, 4'b1000, 1};
        vecs[6]  = '{4'b1111, 4'b1011, 1'b1, 1'b0, 1'b1, 4'b0011, 4'd5,  1'b1, 1'b1, 4'b0011, 1};
        vecs[7]  = '{4'b0111, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b1111, 4'd8,  1'b1, 1'b1, 4'b0011, 1};
        vecs[8]  = '{4'b0110, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0001, 4'd10, 1'b1, 1'b1, 4'b0001, 1};
        vecs[9]  = '{4'b0100, 4'b0110, 1'b1, 1'b1, 1'b0, 4'b1111, 4'd12, 1'b1, 1'b1, 4'b0001, 3};
        vecs[10] = '{4'b1110, 4'b1110, 1'b0, 1'b0, 1'b0, 4'b1111, 4'd0,  1'b1, 1'b1, 4'b0001, 1};
        vecs[11] = '{4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0010, 4'd0,  1'b1, 1'b0, 4'b0010, 1};
        vecs[12] = '{4'b1110, 4'b1101, 1'b1, 1'b0, 1'b1, 4'b1111, 4'd11, 1'b0, 1'b0, 4'b0010, 1};
        vecs[13] = '{4'b0000, 4'b0011, 1'b0, 1'b1, 1'b1, 4'b1111, 4'd12, 1'b0, 1'b0, 4'b0010, 1};
        vecs[14] = '{4'b1000, 4'b0101, 1'b1, 1'b0, 1'b0, 4'b1010, 4'd2,  1'b1, 1'b0, 4'b1010, 1};
        vecs[15] = '{4'b0101, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0101, 4'd9,  1'b1, 1'b1, 4'b0101, 1};
        vecs[16] = '{4'b1010, 4'b1001, 1'b1, 1'b0, 1'b0, 4'b1100, 4'd1,  1'b1, 1'b0, 4'b1100, 1};
        vecs[17] = '{4'b0000, 4'b1110, 1'b0, 1'b1, 1'b1, 4'b0111, 4'd12, 1'b1, 1'b1, 4'b0111, 3};
        vecs[18] = '{4'b0100, 4'b1010, 1'b1, 1'b0, 1'b1, 4'b1111, 4'd0,  1'b0, 1'b0, 4'b0111, 1};
        vecs[19] = '{4'b0010, 4'b0111, 1'b1, 1'b0, 1'b0, 4'b1111, 4'd1,  1'b0, 1'b0, 4'b0111, 1};
        vecs[20] = '{4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1111, 4'd8,  1'b1, 1'b1, 4'b0111, 1};

        reset = 1'b0;
        drive_op(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_code", o_ALU_OpCode, 0);
        check("rst_pass", o_CondPass, 0);
        check("rst_wb", o_WriteBack, 0);
        check("rst_cpsr", o_CPSR, 0);
        check("rst_busy", o_Busy, 0);
        reset = 1'b1;

        // Directed table: each op issued from idle, CPSR carried through the list.
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            drive_op(vecs[k].op, vecs[k].cond, vecs[k].dp, vecs[k].mul, vecs[k].s,
                     vecs[k].flags);
            #1;
            check($sformatf("vec%0d_ready", k), o_ready, 1);
            @(negedge clk);
            i_valid = 1'b0;
            lat = 1;
            while (!o_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d_lat", k), lat, vecs[k].lat);
            check($sformatf("vec%0d_code", k), o_ALU_OpCode, vecs[k].code);
            check($sformatf("vec%0d_pass", k), o_CondPass, vecs[k].pass);
            check($sformatf("vec%0d_wb", k), o_WriteBack, vecs[k].wb);
            @(negedge clk);
            check($sformatf("vec%0d_cpsr", k), o_CPSR, vecs[k].cpsr_after);
            check($sformatf("vec%0d_idle", k), o_valid, 0);
        end

        // Reset in the middle of a MUL wait.
        @(negedge clk);
        drive_op(4'b0000, 4'b1110, 1'b0, 1'b1, 1'b0, 4'b1111);
        @(negedge clk);
        i_valid = 1'b0;
        check("mulrst_busy_before", o_Busy, 1);
        #2 reset = 1'b0;
        #1;
        check("mulrst_valid", o_valid, 0);
        check("mulrst_busy", o_Busy, 0);
        check("mulrst_code", o_ALU_OpCode, 0);
        check("mulrst_pass", o_CondPass, 0);
        check("mulrst_wb", o_WriteBack, 0);
        check("mulrst_cpsr", o_CPSR, 0);
        check("mulrst_ready", o_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mulrst_no_valid", o_valid, 0);
        end

        // CMP then BEQ back-to-back.
        @(negedge clk);
        drive_op(4'b1010, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b0100);
        @(negedge clk);
        check("cmp_valid", o_valid, 1);
        check("cmp_wb", o_WriteBack, 0);
        drive_op(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0100);
        #1;
        bubbles = 0;
        while (!o_ready && bubbles < 5) begin
            @(negedge clk);
            #1;
            bubbles++;
        end
        check("beq_bubbles", bubbles, FWD ? 0 : 1);
        @(negedge clk);
        i_valid = 1'b0;
        check("beq_valid", o_valid, 1);
        check("beq_pass", o_CondPass, 1);
        check("beq_code", o_ALU_OpCode, 0);
        check("beq_wb", o_WriteBack, 1);
        check("beq_cpsr", o_CPSR, 4'b0100);
        @(negedge clk);

        // MUL busy window.
        @(negedge clk);
        drive_op(4'b0000, 4'b1110, 1'b1, 1'b1, 1'b0, 4'b1111);
        @(negedge clk);
        i_valid = 1'b0;
        busy = 0;
        while (o_Busy && busy < 10) begin
            check("mul_ready_busy", o_ready, 0);
            busy++;
            @(negedge clk);
        end
        check("mul_busy_cycles", busy, 2);
        check("mul_valid", o_valid, 1);
        check("mul_code", o_ALU_OpCode, 12);
        @(negedge clk);

        // Execute stalls for four cycles on a flag setter.
        @(negedge clk);
        drive_op(4'b0100, 4'b1110, 1'b1, 1'b0, 1'b1, 4'b1001);
        i_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check("stall_valid", o_valid, 1);
            check("stall_code", o_ALU_OpCode, 0);
            check("stall_wb", o_WriteBack, 1);
            check("stall_ready", o_ready, 0);
            check("stall_cpsr", o_CPSR, 4'b0100);
        end
        i_ready = 1'b1;
        @(negedge clk);
        check("stall_commit", o_CPSR, 4'b1001);
        check("stall_idle", o_valid, 0);

        // Randomized run against the transaction model.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        have_op = 1'b0;
        due = 0;
        cpsr_m = 4'b0000;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            i_valid         = ($urandom_range(0, 3) != 0);
            i_ready         = ($urandom_range(0, 3) != 0);
            i_OpCode        = 4'($urandom);
            i_Cond          = 4'($urandom);
            i_IfDP          = ($urandom_range(0, 4) != 0);
            i_IfMul         = ($urandom_range(0, 5) == 0);
            i_Set_Condition = 1'($urandom);
            i_ALU_Flags     = 4'($urandom);
            #1;
            exp_valid = have_op && (t >= due);
            exp_busy  = have_op && (t < due);
            exp_ready = !have_op || ((t >= due) && i_ready && (FWD || !m_op.fw));
            check("rnd_valid", o_valid, exp_valid);
            check("rnd_busy", o_Busy, exp_busy);
            check("rnd_ready", o_ready, exp_ready);
            check("rnd_cpsr", o_CPSR, cpsr_m);
            if (exp_valid) begin
                check("rnd_code", o_ALU_OpCode, m_op.code);
                check("rnd_pass", o_CondPass, m_op.pass);
                check("rnd_wb", o_WriteBack, m_op.wb);
            end
            commit = exp_valid && i_ready && m_op.fw;
            cflags = (FWD && commit) ? i_ALU_Flags : cpsr_m;
            acc    = i_valid && exp_ready;
            if (exp_valid && i_ready) have_op = 1'b0;
            if (commit) cpsr_m = i_ALU_Flags;
            if (acc) begin
                m_op    = model(i_OpCode, i_Cond, i_IfDP, i_IfMul, i_Set_Condition, cflags);
                have_op = 1'b1;
                due     = t + m_op.lat;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
